cache_req_driver: RTL
=====================

Name: cache_req_driver

Overview:
- Sequencer between the 16-entry request ROM (34-bit entries: valid, write, addr) and the cache's CPU-side port.
- Drives the ROM index, registers each entry into a cache request and holds it while the cache stalls.
- Advances the index one entry per completed transaction and generates deterministic write data.
- Captures read data, counts cycles, requests and misses, and flags stall timeouts; used for the cache bring-up and demo run.

Parameters:
- ROM_DEPTH, 16, number of ROM entries; index width is clog2(ROM_DEPTH)=4.
- STALL_TIMEOUT, 1024, maximum consecutive stall cycles on one request before ERROR.
- CNT_W, 16, width of the performance counters; counters saturate.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE, or restarts from DONE/ERROR
- index  out  4  ROM entry index
- inst_valid  in  1  ROM bit 33; 0 marks end of program
- inst_write  in  1  ROM bit 32
- inst_addr  in  32  ROM bits 31:0
- cpu_req_valid  out  1  request to cache
- cpu_req_write  out  1  1 = write, 0 = read
- cpu_req_addr  out  32  request address
- cpu_req_wdata  out  32  write data, equal to cpu_req_addr XOR 32'hA5A5_A5A5
- cache_stall  in  1  cache busy; the request is held while this is high
- cache_rdata  in  32  read data, valid in the completing cycle of a read
- rd_valid  out  1  one-cycle pulse after a read completes
- rd_data  out  32  captured read data, held until the next read
- busy  out  1  high in LOAD or REQ
- done  out  1  high in DONE
- error  out  1  high in ERROR
- cycle_cnt  out  CNT_W  cycles spent in REQ
- req_cnt  out  CNT_W  completed transactions
- miss_cnt  out  CNT_W  transactions that saw at least one stall cycle

Behaviour:
- Reset:
  - state=IDLE; index=0.
  - All request outputs, rd_valid, rd_data, counters, busy, done and error are 0.
  - Async assertion drops cpu_req_valid immediately, including mid-transaction.
- ROM read is combinational: inst_* reflect the current index in the same cycle.
- IDLE: outputs quiet. start moves to LOAD; counters and index are cleared to 0 in the same edge.
- LOAD (exactly 1 cycle):
  - If inst_valid=1: register write/addr/wdata, set cpu_req_valid, index<=index+1, go to REQ.
  - If inst_valid=0: go to DONE with no request issued.
- REQ (cpu_req_valid=1, request fields stable):
  - cycle_cnt increments every cycle in this state.
  - Completion occurs in a cycle with cache_stall=0. On completion:
    - req_cnt+1.
    - miss_cnt+1 if the stall flag is set.
    - For a read, rd_data<=cache_rdata and rd_valid pulses on the next cycle.
  - Next action at completion:
    - If the completed request came from entry ROM_DEPTH-1, go to DONE; there is no wrap.
    - Else if inst_valid=1, load the next entry in the same edge and stay in REQ (back-to-back, 1 cycle per hit).
    - Else go to DONE; cpu_req_valid=0 next cycle.
  - cache_stall=1: hold all request fields, set the stall flag, increment the stall counter.
  - Stall counter reaches STALL_TIMEOUT: go to ERROR, drop cpu_req_valid; the transaction is not counted.
  - Stall flag and stall counter clear whenever a new request is loaded.
- DONE / ERROR: sticky; counters frozen. start returns to LOAD with counters and index cleared.
- A start pulse while busy is ignored.
- Counters saturate at all-ones.

Decomposition:
- Package cache_drv_pkg:
  - State enum {IDLE, LOAD, REQ, DONE, ERROR}.
  - ROM bit-position constants (VALID_BIT=33, WRITE_BIT=32).
  - WDATA_MASK=32'hA5A5_A5A5.
  - Request struct {valid, write, addr, wdata}.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
- Hit run: ROM 7 valid entries then invalid, cache_stall=0 → start, 1 LOAD cycle, 7 consecutive REQ cycles; final counts cycle_cnt=7, req_cnt=7, miss_cnt=0, done=1 one cycle after the last completion.
- Miss hold: entry 0 read 0x00000004, stall high 17 cycles, cache_rdata=0x12345678 at completion → request fields stable for all 18 cycles; rd_valid pulses with rd_data=0x12345678; cycle_cnt=18, miss_cnt=1.
- Write data: entry write 0x00000018 → cpu_req_write=1, cpu_req_wdata=0xA5A5A5BD.
- Empty program: ROM[0] valid=0 → LOAD then DONE; cpu_req_valid never asserted; req_cnt=0.
- Timeout: STALL_TIMEOUT=8, stall held high → ERROR after 8 stall cycles; error=1; cpu_req_valid=0; req_cnt=0.
- Reset mid-stall (cycle 5 of a miss), then full ROM of 16 valid entries after restart → on reset, outputs zero immediately and state=IDLE; after restart, DONE after entry 15 with req_cnt=16 and index not wrapped.

Source files
------------

// File: rtl/cache_drv_pkg.sv
// Shared types and constants for the cache request sequencer: FSM states,
// ROM word layout, write-data mask and the registered request bundle.
package cache_drv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        REQ   = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

    localparam int ROM_W     = 34;
    localparam int VALID_BIT = 33;
    localparam int WRITE_BIT = 32;

    localparam logic [31:0] WDATA_MASK = 32'hA5A5_A5A5;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cache_req_t;

    // Write data is a fixed scramble of the address so a later read-back can be predicted.
    function automatic logic [31:0] gen_wdata(input logic [31:0] addr);
        return addr ^ WDATA_MASK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_req_driver.sv
// Walks the request ROM and drives the cache CPU port one transaction at a time,
// holding each request through stalls and keeping cycle/request/miss statistics.
module cache_req_driver
    import cache_drv_pkg::*;
#(
    parameter int ROM_DEPTH     = 16,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [$clog2(ROM_DEPTH)-1:0] index,
    input  logic                         inst_valid,
    input  logic                         inst_write,
    input  logic [31:0]                  inst_addr,
    output logic                         cpu_req_valid,
    output logic                         cpu_req_write,
    output logic [31:0]                  cpu_req_addr,
    output logic [31:0]                  cpu_req_wdata,
    input  logic                         cache_stall,
    input  logic [31:0]                  cache_rdata,
    output logic                         rd_valid,
    output logic [31:0]                  rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             req_cnt,
    output logic [CNT_W-1:0]             miss_cnt
);

    localparam int IDX_W   = $clog2(ROM_DEPTH);
    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(ROM_DEPTH - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    cache_req_t         req_q, req_d;
    logic               last_q, last_d;
    logic               stall_flag_q, stall_flag_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               busy_q, done_q, error_q;

    logic [ROM_W-1:0]   rom_word_s;
    logic               load_s;
    logic               cnt_clr_s;
    logic               cyc_inc_s;
    logic               req_inc_s;
    logic               miss_inc_s;

    assign rom_word_s = {inst_valid, inst_write, inst_addr};

    // FSM next state, request loading and completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        req_d        = req_q;
        last_d       = last_q;
        stall_flag_d = stall_flag_q;
        stall_cnt_d  = stall_cnt_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        load_s       = 1'b0;
        cnt_clr_s    = 1'b0;
        cyc_inc_s    = 1'b0;
        req_inc_s    = 1'b0;
        miss_inc_s   = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = LOAD;
                    index_d   = '0;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (rom_word_s[VALID_BIT]) begin
                    load_s  = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = DONE;
                end
            end
            REQ: begin
                cyc_inc_s = 1'b1;
                if (cache_stall) begin
                    if (stall_cnt_q == STALL_LAST) begin
                        // Timed-out transaction is abandoned and not counted.
                        state_d     = ERROR;
                        req_d.valid = 1'b0;
                    end else begin
                        stall_flag_d = 1'b1;
                        stall_cnt_d  = stall_cnt_q + STALL_ONE;
                    end
                end else begin
                    req_inc_s  = 1'b1;
                    miss_inc_s = stall_flag_q;
                    if (!req_q.write) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = cache_rdata;
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                    if (last_q) begin
                        state_d     = DONE;
                        req_d.valid = 1'b0;
                    end else if (rom_word_s[VALID_BIT]) begin
                        load_s = 1'b1;
                    end else begin
                        state_d     = DONE;
                        req_d.valid = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                req_d.valid = 1'b0;
            end
        endcase

        // The index parks on the final entry instead of wrapping; last_q ends the run.
        if (load_s) begin
            req_d.valid  = 1'b1;
            req_d.write  = rom_word_s[WRITE_BIT];
            req_d.addr   = rom_word_s[31:0];
            req_d.wdata  = gen_wdata(rom_word_s[31:0]);
            last_d       = (index_q == LAST_IDX);
            index_d      = (index_q == LAST_IDX) ? index_q : (index_q + IDX_ONE);
            stall_flag_d = 1'b0;
            stall_cnt_d  = '0;
        end else begin
            last_d = last_q;
        end
    end

    // State, request and read-capture registers; status flags registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            req_q        <= '0;
            last_q       <= 1'b0;
            stall_flag_q <= 1'b0;
            stall_cnt_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            req_q        <= req_d;
            last_q       <= last_d;
            stall_flag_q <= stall_flag_d;
            stall_cnt_q  <= stall_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= (state_d == LOAD) || (state_d == REQ);
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ERROR);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_s),
        .inc_i (cyc_inc_s),
        .cnt_o (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_s),
        .inc_i (req_inc_s),
        .cnt_o (req_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_s),
        .inc_i (miss_inc_s),
        .cnt_o (miss_cnt)
    );

    assign index         = index_q;
    assign cpu_req_valid = req_q.valid;
    assign cpu_req_write = req_q.write;
    assign cpu_req_addr  = req_q.addr;
    assign cpu_req_wdata = req_q.wdata;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule
